column_rx: RTL and testbench
============================

COLUMN_RX -- requirements
Module: column_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 7, payload bits per frame.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth on clk_in and bit_in (minimum 2).
REQ-003 SHALL have parameter TIMEOUT, default 4096, maximum clk cycles allowed between link edges mid-frame.
REQ-004 SHALL have port clk  input  1  system clock; one clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port clk_in  input  1  asynchronous link strobe from remote sender.
REQ-007 SHALL have port bit_in  input  1  asynchronous link data, stable around clk_in rising edge.
REQ-008 SHALL have port ack  input  1  consumer accepts the held word.
REQ-009 SHALL have port column_select  output  WIDTH  last accepted payload, registered.
REQ-010 SHALL have port valid  output  1  column_select holds an unacknowledged word.
REQ-011 SHALL have port ready_out  output  1  to remote sender: receiver idle, new frame may start.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse on aborted frame.

Function
REQ-013 SHALL pass clk_in and bit_in through identical SYNC_STAGES-deep flop chains so both stay aligned.
REQ-014 SHALL register the synchronised strobe into prev; link edge = synchronised strobe 1 and prev 0.
REQ-015 SHALL detect a link edge SYNC_STAGES+1 clk cycles after a clean raw clk_in rise; bit sampled in that same cycle.
REQ-016 Frame format SHALL be: start bit 1, then WIDTH data bits MSB first, then (PARITY_EN only) one even-parity bit.
REQ-017 FSM states SHALL be IDLE, DATA, PARITY, HOLD.
REQ-018 IDLE: edge with bit 1 -> DATA, bit counter cleared; edge with bit 0 ignored, no frame_err.
REQ-019 DATA: each edge shifts bit into shift register; after WIDTH-th bit -> PARITY if PARITY_EN, else HOLD.
REQ-020 PARITY: on edge, if XOR of data bits and parity bit is 0 -> HOLD, else -> IDLE with frame_err pulse.
REQ-021 On entry to HOLD, column_select SHALL load the shift register and valid SHALL rise in the same cycle (one cycle after final sampled edge).
REQ-022 HOLD: valid held 1 until ack sampled 1; then valid 0 and state IDLE next cycle; link edges in HOLD ignored.
REQ-023 ack while valid 0 SHALL be ignored.
REQ-024 column_select SHALL change only on HOLD entry; it holds its value through errors, ack and IDLE.
REQ-025 ready_out SHALL be 1 exactly when state is IDLE and reset is 0.
REQ-026 In DATA or PARITY, timeout counter SHALL clear on each edge and increment otherwise; reaching TIMEOUT-1 -> IDLE, frame_err pulse, partial word discarded.
REQ-027 frame_err SHALL be 1 for exactly one cycle per abort and 0 otherwise.
REQ-028 Timeout and a link edge in the same cycle: the edge SHALL win (no abort).

Reset
REQ-029 While reset is 1, next state SHALL be IDLE, with column_select 0, valid 0, frame_err 0, ready_out 0, counters 0.
REQ-030 prev SHALL reset to 1; synchroniser flops SHALL NOT be reset, so a clk_in held high through reset produces no edge.
REQ-031 Reset mid-frame or in HOLD SHALL discard the partial/held word, with no frame_err and no valid.
REQ-032 ready_out SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-033 Macro COLUMN_RX_PARITY_EN defined: PARITY state and parity bit compiled in; parity mismatch aborts per REQ-020.
REQ-034 Macro COLUMN_RX_PARITY_EN undefined: PARITY state absent; frame = 1+WIDTH bits; parity-error frame_err never occurs.

Verification
REQ-035 Parity off; send start, 7'b0000100 -> column_select 7'h04, valid 1 one cycle after last sampled edge, ready_out 0 until ack.
REQ-036 Parity on; send start, 7'b1010011, parity 0 -> valid 1, column_select 7'h53; repeat with parity 1 -> frame_err one pulse, valid 0, column_select unchanged.
REQ-037 Send start plus 3 bits, then no edge for 4096 cycles -> frame_err pulse at timeout, ready_out 1 next cycle, column_select unchanged.
REQ-038 valid 1; send a second full frame without ack -> column_select unchanged; then ack 1 -> valid 0, ready_out 1 next cycle.
REQ-039 Assert reset after 4 data bits with clk_in held high, then deassert -> no edge detected, ready_out 1, valid 0, column_select 0.
REQ-040 In IDLE, send edge with bit_in 0 -> state stays IDLE, no frame_err; a following valid frame 7'h7F is received correctly.

Source files
------------

// File: rtl/column_rx.sv
// column_rx: receives frames from an asynchronous strobe/data link and
// presents each payload as column_select with a valid/ack handshake.
// A frame is a start bit (1), then WIDTH data bits MSB first, then an
// optional even-parity bit.
// Optional feature: define COLUMN_RX_PARITY_EN to add the parity bit
// and the PARITY state.
// WIDTH must be at least 2 and SYNC_STAGES at least 2.
module column_rx #(
    parameter int WIDTH       = 7,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_in,
    input  logic             bit_in,
    input  logic             ack,
    output logic [WIDTH-1:0] column_select,
    output logic             valid,
    output logic             ready_out,
    output logic             frame_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
`ifdef COLUMN_RX_PARITY_EN
    localparam logic [1:0] PARITY = 2'd2;
`endif
    localparam logic [1:0] HOLD   = 2'd3;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] bit_sync;
    logic                   clk_s;
    logic                   bit_s;
    logic                   prev;
    logic                   link_edge;
    logic [1:0]             state;
    logic [CW-1:0]          bit_cnt;
    logic [TW-1:0]          tmo;
    logic [WIDTH-1:0]       shreg;
    logic [WIDTH-1:0]       shift_nxt;

    // Synchronisers: identical depth on strobe and data keeps them aligned.
    // Deliberately not reset so a strobe held high through reset stays high.
    always_ff @(posedge clk) begin
        clk_sync <= {clk_sync[SYNC_STAGES-2:0], clk_in};
        bit_sync <= {bit_sync[SYNC_STAGES-2:0], bit_in};
    end

    assign clk_s     = clk_sync[SYNC_STAGES-1];
    assign bit_s     = bit_sync[SYNC_STAGES-1];
    assign link_edge = clk_s & ~prev;
    assign shift_nxt = {shreg[WIDTH-2:0], bit_s};
    assign ready_out = (state == IDLE) && !reset;

    // Frame FSM, payload capture, mid-frame timeout and abort pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev          <= 1'b1;
            state         <= IDLE;
            bit_cnt       <= '0;
            tmo           <= '0;
            shreg         <= '0;
            column_select <= '0;
            valid         <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            prev      <= clk_s;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    // A 0 on an idle edge is line noise, not a start bit.
                    if (link_edge && bit_s) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        tmo     <= '0;
                    end
                end
                DATA: begin
                    if (link_edge) begin
                        // An edge beats a timeout landing in the same cycle.
                        shreg   <= shift_nxt;
                        tmo     <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == CW'(WIDTH - 1)) begin
`ifdef COLUMN_RX_PARITY_EN
                            state <= PARITY;
`else
                            state         <= HOLD;
                            column_select <= shift_nxt;
                            valid         <= 1'b1;
`endif
                        end
                    end else if (tmo == TW'(TIMEOUT - 1)) begin
                        state     <= IDLE;
                        tmo       <= '0;
                        frame_err <= 1'b1;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
`ifdef COLUMN_RX_PARITY_EN
                PARITY: begin
                    if (link_edge) begin
                        tmo <= '0;
                        if (^{shreg, bit_s} == 1'b0) begin
                            state         <= HOLD;
                            column_select <= shreg;
                            valid         <= 1'b1;
                        end else begin
                            state     <= IDLE;
                            frame_err <= 1'b1;
                        end
                    end else if (tmo == TW'(TIMEOUT - 1)) begin
                        state     <= IDLE;
                        tmo       <= '0;
                        frame_err <= 1'b1;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
`endif
                HOLD: begin
                    // Link edges are ignored until the consumer takes the word.
                    if (ack) begin
                        valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_column_rx.sv
// Scoreboard bench for column_rx: stimulus pushes expected words / aborts,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_column_rx;
    localparam int WIDTH       = 7;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 4096;

    logic clk = 0, reset = 1, clk_in = 0, bit_in = 0, ack = 0;
    logic [WIDTH-1:0] column_select;
    logic valid, ready_out, frame_err;

    int n_chk = 0, n_fail = 0;
    logic [WIDTH-1:0] exp_q[$];
    int err_pend = 0;

    always #5 clk = ~clk;

    column_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .clk_in(clk_in), .bit_in(bit_in), .ack(ack),
        .column_select(column_select), .valid(valid), .ready_out(ready_out),
        .frame_err(frame_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares presented words and abort pulses against expectations.
    logic valid_q = 0, ferr_q = 0, rst_q = 1, allowed;
    logic [WIDTH-1:0] cs_q = '0, w_exp;
    always @(negedge clk) begin
        if (valid && !valid_q) begin
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_valid: got word %0h expected none", column_select);
            end else begin
                w_exp = exp_q.pop_front();
                chk("word", 32'(column_select), 32'(w_exp));
            end
        end
        if (frame_err) begin
            chk("frame_err_single_cycle", 32'(ferr_q), 0);
            n_chk++;
            if (err_pend == 0) begin
                n_fail++;
                $display("FAIL unexpected_frame_err: got pulse expected none at %0t", $time);
            end else err_pend--;
        end
        if (column_select !== cs_q) begin
            allowed = (valid && !valid_q) || rst_q;
            chk("cs_change_only_on_hold_entry", 32'(allowed), 1);
        end
        valid_q = valid; ferr_q = frame_err; rst_q = reset; cs_q = column_select;
    end

    // One link bit: data set first, strobe high long enough to be seen, then low.
    task automatic link_bit(input logic b);
        @(posedge clk); #2 bit_in = b;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #2 clk_in = 1;
        repeat ($urandom_range(4, 7)) @(posedge clk);
        #2 clk_in = 0;
        repeat ($urandom_range(4, 7)) @(posedge clk);
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] w, input logic par_ok, input logic expect_out);
        logic good;
`ifdef COLUMN_RX_PARITY_EN
        good = par_ok;
`else
        good = 1'b1;
`endif
        if (expect_out) begin
            if (good) exp_q.push_back(w);
            else err_pend++;
        end
        link_bit(1'b1);
        for (int i = WIDTH - 1; i >= 0; i--) link_bit(w[i]);
`ifdef COLUMN_RX_PARITY_EN
        link_bit((^w) ^ !par_ok);
`endif
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        @(negedge clk);
        while (!valid && k < 300) begin @(negedge clk); k++; end
        n_chk++;
        if (!valid) begin
            n_fail++;
            $display("FAIL %s: got valid 0 expected 1 within 300 cycles", name);
        end else chk("ready_low_in_hold", 32'(ready_out), 0);
    endtask

    task automatic do_ack();
        repeat ($urandom_range(0, 4)) @(posedge clk);
        #2 ack = 1;
        @(posedge clk); #2 ack = 0;
        @(negedge clk);
        chk("valid_after_ack", 32'(valid), 0);
        chk("ready_after_ack", 32'(ready_out), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] w, hold_w;
        logic             pok;
        int               k;

        // Reset state
        repeat (4) @(negedge clk);
        chk("rst_ready", 32'(ready_out), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_ferr", 32'(frame_err), 0);
        chk("rst_cs", 32'(column_select), 0);
        @(posedge clk); #2 reset = 0;
        @(negedge clk);
        chk("ready_after_reset", 32'(ready_out), 1);

        // Ack while nothing held is ignored
        @(posedge clk); #2 ack = 1;
        repeat (3) @(posedge clk); #2 ack = 0;
        @(negedge clk);
        chk("idle_ack_valid", 32'(valid), 0);
        chk("idle_ack_ready", 32'(ready_out), 1);

        // Basic frame 7'h04
        send_frame(7'h04, 1'b1, 1'b1);
        wait_valid("frame_04");
        do_ack();

`ifdef COLUMN_RX_PARITY_EN
        // Good then bad parity on 7'h53
        send_frame(7'h53, 1'b1, 1'b1);
        wait_valid("frame_53");
        do_ack();
        send_frame(7'h53, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        chk("bad_parity_valid", 32'(valid), 0);
        chk("bad_parity_cs", 32'(column_select), 32'h53);
`endif

        // Randomized frames
        for (int i = 0; i < 20; i++) begin
            w   = WIDTH'($urandom);
`ifdef COLUMN_RX_PARITY_EN
            pok = ($urandom_range(0, 3) != 0);
`else
            pok = 1'b1;
`endif
            send_frame(w, pok, 1'b1);
            if (pok) begin
                wait_valid("random_frame");
                do_ack();
            end else repeat (20) @(negedge clk);
        end

        // Idle edge with bit 0 ignored, then 7'h7F
        link_bit(1'b0);
        @(negedge clk);
        chk("zero_edge_ready", 32'(ready_out), 1);
        send_frame(7'h7F, 1'b1, 1'b1);
        wait_valid("frame_7f");
        do_ack();
        hold_w = 7'h7F;

        // Timeout: start plus 3 bits, then silence
        err_pend++;
        link_bit(1'b1); link_bit(1'b0); link_bit(1'b1); link_bit(1'b1);
        k = 0;
        @(negedge clk);
        while (!frame_err && k < TIMEOUT + 50) begin @(negedge clk); k++; end
        chk("timeout_fired", 32'(frame_err), 1);
        chk("timeout_not_early", 32'(k > TIMEOUT - 40), 1);
        @(negedge clk);
        chk("timeout_ready", 32'(ready_out), 1);
        chk("timeout_cs", 32'(column_select), 32'(hold_w));

        // Second frame while holding is ignored
        send_frame(7'h15, 1'b1, 1'b1);
        wait_valid("frame_15");
        send_frame(7'h6A, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        chk("hold_valid", 32'(valid), 1);
        chk("hold_cs", 32'(column_select), 32'h15);
        do_ack();

        // Reset mid-frame with strobe held high
        link_bit(1'b1); link_bit(1'b1); link_bit(1'b0); link_bit(1'b1);
        @(posedge clk); #2 bit_in = 1;
        repeat (2) @(posedge clk); #2 clk_in = 1;
        repeat (6) @(posedge clk); #2 reset = 1;
        repeat (3) @(posedge clk); #2 reset = 0;
        repeat (10) @(negedge clk);
        chk("mid_reset_ready", 32'(ready_out), 1);
        chk("mid_reset_valid", 32'(valid), 0);
        chk("mid_reset_cs", 32'(column_select), 0);
        @(posedge clk); #2 clk_in = 0;
        repeat (6) @(posedge clk);
        send_frame(7'h2C, 1'b1, 1'b1);
        wait_valid("frame_after_reset");
        do_ack();

        repeat (10) @(negedge clk);
        chk("exp_queue_drained", 32'(exp_q.size()), 0);
        chk("err_pending_drained", 32'(err_pend), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
